// File: rtl/lc3b_mem_pkg.sv
// Shared definitions for the LC-3b memory access controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lc3b_mem_pkg;

   // Controller states. The values are fixed so that traces stay comparable
   // with the older decoded-state implementation.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } mem_state_e;

   localparam logic RW_READ   = 1'b0;
   localparam logic RW_WRITE  = 1'b1;
   localparam logic SIZE_BYTE = 1'b0;
   localparam logic SIZE_WORD = 1'b1;

   // Access latency, in cycles from request acceptance to the ready pulse.
   // The legal range is 2..15, so it always fits a 4-bit counter.
   localparam int LAT_DEFAULT = 5;

   // Byte stores replicate the low byte onto both lanes. mem16 then picks
   // the lane from addr[0], so the controller never has to steer data.
   function automatic logic [15:0] lane_wdata(input logic [15:0] data,
                                              input logic        size);
      return (size == SIZE_WORD) ? data : {data[7:0], data[7:0]};
   endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that paces the memory access latency.
// Latency: load/decrement take effect on the next rising edge; zero is combinational from the count.
// Backpressure: none; dec is ignored once the count reaches zero.
//
// Ports:
//   clk, reset       clock, async active-high reset (count clears to 0)
//   load, load_val   load a new count (load has priority over dec)
//   dec              decrement while nonzero
//   zero             count == 0
module mem_lat_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle LC-3b memory access controller between MAR/MDR and mem16.
// Latency: ready pulses in the cycle after edge t0+LATENCY, where t0 is the acceptance edge. A misaligned word access pulses one cycle after acceptance.
// Backpressure: accepts req only in IDLE; the requester holds req until ready, and changes to the inputs outside IDLE are ignored.
//
// Ports:
//   clk, reset          clock, async active-high reset (aborts any access)
//   req, rw, word       request (MIO.EN), 1=write, 1=word access
//   addr, wdata         byte address (MAR) and write data (MDR)
//   ready, err, rdata   one-cycle completion pulse, misalignment flag, read result
//   mem_addr/wdata/word stable memory-side address, data and size (ir14)
//   mem_we_n            active-low write strobe, one full cycle per write
//   mem_rdata           read data from mem16 (byte reads already sign-extended)
module mem_access_ctrl
   import lc3b_mem_pkg::*;
#(
   parameter int LATENCY = LAT_DEFAULT,
   parameter int CNT_W   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        rw,
   input  logic        word,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic        ready,
   output logic [15:0] rdata,
   output logic        err,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_word,
   output logic        mem_we_n,
   input  logic [15:0] mem_rdata
);

   mem_state_e state;
   logic       rw_q;
   logic       err_q;
   logic       accept;
   logic       misalign;
   logic       cnt_load;
   logic       cnt_dec;
   logic       cnt_zero;

   assign accept   = (state == IDLE) && req;
   assign misalign = (word == SIZE_WORD) && addr[0];

   // Misaligned requests skip the counter and go straight to DONE.
   assign cnt_load = accept && !misalign;
   assign cnt_dec  = (state == WAIT);

   mem_lat_counter #(
      .CNT_W (CNT_W)
   ) u_lat_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (CNT_W'(LATENCY - 1)),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         rw_q      <= RW_READ;
         err_q     <= 1'b0;
         rdata     <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_word  <= SIZE_BYTE;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  // The memory-side registers are loaded even for a misaligned
                  // request. The strobe is gated by state, so no memory
                  // operation results.
                  mem_addr  <= addr;
                  mem_word  <= word;
                  mem_wdata <= lane_wdata(wdata, word);
                  rw_q      <= rw;
                  err_q     <= misalign;
                  state     <= misalign ? DONE : WAIT;
               end
            end
            WAIT: begin
               if (cnt_zero) begin
                  state <= DONE;
                  if (rw_q == RW_READ) begin
                     rdata <= mem_rdata;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // The strobe is decoded from registered state only, so it is glitch-free.
   // It covers the final WAIT cycle, which contains exactly one falling edge.
   // Reset clears the state asynchronously and releases the strobe at once.
   assign mem_we_n = !((state == WAIT) && cnt_zero && (rw_q == RW_WRITE));

   assign ready = (state == DONE);
   assign err   = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        rw;
   logic        word;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic        ready;
   logic [15:0] rdata;
   logic        err;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_word;
   logic        mem_we_n;
   logic [15:0] mem_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_access_ctrl #(
      .LATENCY (5),
      .CNT_W   (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .rw        (rw),
      .word      (word),
      .addr      (addr),
      .wdata     (wdata),
      .ready     (ready),
      .rdata     (rdata),
      .err       (err),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_word  (mem_word),
      .mem_we_n  (mem_we_n),
      .mem_rdata (mem_rdata)
   );

   // Byte-banked mem16 model: little-endian, commits on the falling clock edge
   // while the strobe is low, and sign-extends byte reads.
   logic [7:0] mem [0:255];
   logic [7:0] b_lo, b_hi, b_sel;

   always @(negedge clk) begin
      if (!mem_we_n) begin
         if (mem_word) begin
            mem[{mem_addr[7:1], 1'b0}] <= mem_wdata[7:0];
            mem[{mem_addr[7:1], 1'b1}] <= mem_wdata[15:8];
         end else begin
            mem[mem_addr[7:0]] <= mem_wdata[7:0];
         end
      end
   end

   always_comb begin
      b_lo      = mem[{mem_addr[7:1], 1'b0}];
      b_hi      = mem[{mem_addr[7:1], 1'b1}];
      b_sel     = mem[mem_addr[7:0]];
      mem_rdata = mem_word ? {b_hi, b_lo} : {{8{b_sel[7]}}, b_sel};
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Runs one access. Cycle n counts the edges from acceptance: n=1 is the
   // sample taken just after the acceptance edge t0.
   task automatic do_access(input logic w, input logic wd, input logic [15:0] a,
                            input logic [15:0] d,
                            output int rdy_n, output int we_at, output int we_cnt,
                            output logic [15:0] wd_seen, output logic [15:0] wa_seen,
                            output logic err_seen);
      @(negedge clk);
      req = 1'b1; rw = w; word = wd; addr = a; wdata = d;
      rdy_n = -1; we_at = -1; we_cnt = 0;
      wd_seen = '0; wa_seen = '0; err_seen = 1'b0;
      for (int n = 1; n <= 40 && rdy_n < 0; n++) begin
         @(posedge clk); #1;
         // Scramble the inputs once the access has been accepted.
         if (n == 1) begin addr = ~a; wdata = ~d; end
         if (!mem_we_n) begin
            we_cnt++; we_at = n; wd_seen = mem_wdata; wa_seen = mem_addr;
         end
         if (ready) begin
            rdy_n = n; err_seen = err; req = 1'b0;
         end
      end
      if (rdy_n < 0) chk("ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   int          rn, wat, wc, r1, r2;
   logic [15:0] wds, was;
   logic        es;
   logic        found;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      reset = 1'b1; req = 1'b0; rw = 1'b0; word = 1'b0; addr = '0; wdata = '0;
      #1;
      chk("rst_ready",  ready, 0);
      chk("rst_err",    err, 0);
      chk("rst_rdata",  rdata, 0);
      chk("rst_we_n",   mem_we_n, 1);
      chk("rst_maddr",  mem_addr, 0);
      chk("rst_mwdata", mem_wdata, 0);
      chk("rst_mword",  mem_word, 0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;

      // Word write 0x1234 to 0x0040: strobe at n=5 (edge t0+4), ready at n=6.
      do_access(1'b1, 1'b1, 16'h0040, 16'h1234, rn, wat, wc, wds, was, es);
      chk("ww_ready_n", rn, 6);
      chk("ww_we_at",   wat, 5);
      chk("ww_we_cnt",  wc, 1);
      chk("ww_err",     es, 0);
      chk("ww_wdata",   wds, 16'h1234);
      chk("ww_addr",    was, 16'h0040);

      // Word read back.
      do_access(1'b0, 1'b1, 16'h0040, 16'h0000, rn, wat, wc, wds, was, es);
      chk("wr_ready_n", rn, 6);
      chk("wr_we_cnt",  wc, 0);
      chk("wr_rdata",   rdata, 16'h1234);

      // Byte write 0xAB to 0x0041; the high byte of wdata must be ignored.
      do_access(1'b1, 1'b0, 16'h0041, 16'h77AB, rn, wat, wc, wds, was, es);
      chk("bw_we_cnt",  wc, 1);
      chk("bw_wdata",   wds, 16'hABAB);
      chk("bw_err",     es, 0);

      do_access(1'b0, 1'b0, 16'h0041, 16'h0000, rn, wat, wc, wds, was, es);
      chk("br_hi_rdata", rdata, 16'hFFAB);
      do_access(1'b0, 1'b0, 16'h0040, 16'h0000, rn, wat, wc, wds, was, es);
      chk("br_lo_rdata", rdata, 16'h0034);
      do_access(1'b0, 1'b1, 16'h0040, 16'h0000, rn, wat, wc, wds, was, es);
      chk("wr2_rdata",  rdata, 16'hAB34);

      // Misaligned word read: one-cycle turnaround with err, rdata held.
      do_access(1'b0, 1'b1, 16'h0043, 16'h0000, rn, wat, wc, wds, was, es);
      chk("mis_rd_ready_n", rn, 1);
      chk("mis_rd_err",     es, 1);
      chk("mis_rd_we_cnt",  wc, 0);
      chk("mis_rd_rdata",   rdata, 16'hAB34);

      // Misaligned word write must not touch memory.
      do_access(1'b1, 1'b1, 16'h0041, 16'h9999, rn, wat, wc, wds, was, es);
      chk("mis_wr_err",    es, 1);
      chk("mis_wr_we_cnt", wc, 0);

      // Back-to-back: req held through DONE, second read queued.
      @(negedge clk);
      req = 1'b1; rw = 1'b0; word = 1'b1; addr = 16'h0040;
      r1 = -1; r2 = -1;
      for (int n = 1; n <= 60 && r2 < 0; n++) begin
         @(posedge clk); #1;
         if (ready) begin
            if (r1 < 0) begin
               r1 = n;
               chk("b2b_first_rdata", rdata, 16'hAB34);
               chk("b2b_first_err", err, 0);
               word = 1'b0; addr = 16'h0041;
            end else begin
               r2 = n; req = 1'b0;
            end
         end
      end
      chk("b2b_second_seen", (r2 > 0), 1);
      chk("b2b_spacing",     r2 - r1, 7);
      chk("b2b_second_rdata", rdata, 16'hFFAB);
      @(posedge clk); #1;

      // Reset during the write strobe.
      @(negedge clk);
      req = 1'b1; rw = 1'b1; word = 1'b1; addr = 16'h0040; wdata = 16'h5555;
      found = 1'b0;
      for (int n = 1; n <= 20 && !found; n++) begin
         @(posedge clk); #1;
         if (!mem_we_n) found = 1'b1;
      end
      chk("rst_mid_strobe_seen", found, 1);
      reset = 1'b1;
      #1;
      chk("rst_mid_we_n",  mem_we_n, 1);
      chk("rst_mid_ready", ready, 0);
      chk("rst_mid_rdata", rdata, 0);
      req = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid_ready_hold", ready, 0);
      @(negedge clk);
      reset = 1'b0;
      do_access(1'b0, 1'b1, 16'h0040, 16'h0000, rn, wat, wc, wds, was, es);
      chk("post_rst_ready_n", rn, 6);
      chk("post_rst_rdata",   rdata, 16'hAB34);
      chk("post_rst_err",     es, 0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Multi-cycle memory access controller between the LC-3b datapath (MAR/MDR, MIO.EN, R.W, DATA.SIZE) and the byte-banked 16-bit memory (mem16).
- Latches one request, presents a stable address, data and size to memory, and issues exactly one active-low write strobe on writes.
- Captures read data into a result register and raises the one-cycle ready (R) pulse that the microsequencer waits on.
- Rejects misaligned word accesses.

Parameters:
- LATENCY, 5, cycles from request acceptance to ready pulse; legal range 2..15.
- CNT_W, 4, width of the internal latency counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  access request (MIO.EN); sampled only in IDLE.
- rw  input  1  1 = write, 0 = read.
- word  input  1  1 = word access, 0 = byte access (drives the memory's ir14 input).
- addr  input  16  byte address (MAR).
- wdata  input  16  write data (MDR).
- ready  output  1  one-cycle completion pulse (R).
- rdata  output  16  registered read result to MDR.
- err  output  1  valid with ready; 1 = misaligned word access, no memory operation performed.
- mem_addr  output  16  address to mem16.
- mem_wdata  output  16  data to mem16.
- mem_word  output  1  size to mem16 (ir14).
- mem_we_n  output  1  active-low write strobe to mem16.
- mem_rdata  input  16  read data from mem16; byte reads arrive already sign-extended.

Behaviour:
- Reset (asynchronous, immediate): state = IDLE, ready = 0, err = 0, rdata = 0, mem_we_n = 1, mem_addr/mem_wdata = 0, mem_word = 0, counter = 0.
- States:
  - IDLE: wait for req.
  - WAIT: count down the access latency.
  - DONE: issue the ready pulse.
- IDLE with req = 1 at edge t0:
  - Latch addr, rw, word into the memory-side registers.
  - mem_wdata = wdata for a word access; {wdata[7:0], wdata[7:0]} for a byte access.
  - If word = 1 and addr[0] = 1: go to DONE with err = 1. No strobe is issued; rdata is unchanged.
  - Otherwise: go to WAIT with counter = LATENCY-1.
- WAIT:
  - Counter decrements at each edge while it is nonzero.
  - At the edge where counter = 0: go to DONE. On reads, rdata <= mem_rdata at this edge.
- Write strobe: mem_we_n = 0 only while in WAIT with counter = 0 and rw = 1. That is exactly one full clock cycle, containing exactly one falling edge, on which mem16 commits the write. mem_we_n is decoded from registered state only, so it is glitch-free.
- DONE: ready = 1 for one cycle, with err valid; the next state is IDLE.
- Latency: with req accepted at edge t0, ready is high in the cycle after edge t0+LATENCY. Misaligned accesses take 1 cycle.
- Handshake:
  - The requester holds req until it sees ready, then drops it during the DONE cycle.
  - If req is still high in IDLE after DONE, a new access starts. This is legal back-to-back operation.
  - req, addr and wdata changes outside IDLE are ignored. mem_addr, mem_wdata and mem_word are stable for the whole access.
- Byte reads: mem16 selects the lane by addr[0] and sign-extends; rdata passes the value unchanged.
- Reset mid-access aborts the access. If asserted during the strobe cycle, mem_we_n goes high immediately. No ready pulse is issued for the aborted access.

Decomposition:
- Shared package lc3b_mem_pkg holds:
  - state enum {IDLE, WAIT, DONE};
  - constants RW_READ = 0, RW_WRITE = 1, SIZE_BYTE = 0, SIZE_WORD = 1;
  - LATENCY default.
- One natural sub-module, mem_lat_counter: loadable down-counter with a zero flag, parameterised by CNT_W.

Test Plan:
- Word write 0x1234 to address 0x0040, LATENCY = 5 -> mem_we_n low for exactly one cycle (cycle t0+4), ready at t0+5, err = 0; a subsequent word read of 0x0040 returns rdata = 0x1234.
- Byte write 0xAB to address 0x0041, then byte read of 0x0041 -> mem_wdata = 0xABAB; rdata = 0xFFAB; word read of 0x0040 shows the high byte 0xAB with the low byte unchanged.
- Word read of address 0x0043 -> ready one cycle after acceptance with err = 1; mem_we_n never low; rdata holds its previous value.
- req held high through DONE with a second read queued -> second access accepted on the IDLE edge after DONE; two ready pulses spaced LATENCY+2 cycles apart.
- reset asserted while mem_we_n is low during a write -> mem_we_n, ready and rdata clear immediately; memory content unchanged; the next request after reset completes normally.
